// File: rtl/flash_read_arbiter.sv
// Arbitrates the single flash read port between the CPU bus path and the DMA/loader engine.
// Registered grant, one-cycle ready pulses, bounded CPU bursts and a watchdog for hung reads.
module flash_read_arbiter #(
    parameter int ADDRESS_WIDTH  = 24,
    parameter int CPU_BURST_MAX  = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_read_en,
    input  logic [ADDRESS_WIDTH-1:0] cpu_address,
    output logic                     cpu_read_ready,
    output logic [31:0]              cpu_read_data,
    input  logic                     dma_read_en,
    input  logic [ADDRESS_WIDTH-1:0] dma_address,
    output logic                     dma_read_ready,
    output logic [31:0]              dma_read_data,
    output logic                     flash_read_en,
    output logic [ADDRESS_WIDTH-1:0] flash_address,
    input  logic                     flash_read_ready,
    input  logic [31:0]              flash_read_data,
    output logic                     dma_granted,
    output logic                     timeout_error
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CPU     = 2'd1;
    localparam logic [1:0] DMA     = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    localparam int STREAK_W = (CPU_BURST_MAX > 0) ? $clog2(CPU_BURST_MAX + 1) : 1;
    localparam int WD_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(CPU_BURST_MAX);
    localparam logic [WD_W-1:0]     WD_LAST    = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [1:0]          state;
    logic [STREAK_W-1:0] streak;
    logic [WD_W-1:0]     wd_count;
    logic                cpu_wins;
    logic                dma_wins;
    logic                expired;
    logic [31:0]         completion_data;

    // With CPU_BURST_MAX = 0 the streak can never be below the limit, so DMA always wins contention.
    always_comb begin
        cpu_wins        = cpu_read_en && (!dma_read_en || (streak < STREAK_MAX));
        dma_wins        = dma_read_en && !cpu_wins;
        expired         = (TIMEOUT_CYCLES > 0) && (wd_count == WD_LAST);
        completion_data = flash_read_ready ? flash_read_data : 32'hFFFF_FFFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            streak         <= '0;
            wd_count       <= '0;
            flash_read_en  <= 1'b0;
            flash_address  <= '0;
            cpu_read_ready <= 1'b0;
            cpu_read_data  <= '0;
            dma_read_ready <= 1'b0;
            dma_read_data  <= '0;
            dma_granted    <= 1'b0;
            timeout_error  <= 1'b0;
        end else begin
            cpu_read_ready <= 1'b0;
            dma_read_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_wins || dma_wins) begin
                        state         <= cpu_wins ? CPU : DMA;
                        flash_read_en <= 1'b1;
                        flash_address <= cpu_wins ? cpu_address : dma_address;
                        dma_granted   <= dma_wins;
                        wd_count      <= '0;
                        // A contended CPU win implies streak < limit, so the increment cannot overshoot.
                        if (cpu_wins && dma_read_en) begin
                            streak <= streak + 1'b1;
                        end else begin
                            streak <= '0;
                        end
                    end
                end
                CPU, DMA: begin
                    // A real flash response on the expiry cycle wins over the watchdog.
                    if (flash_read_ready || expired) begin
                        if (state == CPU) begin
                            cpu_read_data  <= completion_data;
                            cpu_read_ready <= 1'b1;
                        end else begin
                            dma_read_data  <= completion_data;
                            dma_read_ready <= 1'b1;
                        end
                        if (!flash_read_ready) begin
                            timeout_error <= 1'b1;
                        end
                        flash_read_en <= 1'b0;
                        state         <= RELEASE;
                    end else begin
                        wd_count <= wd_count + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
